// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter: round-robin sharing of one sequential multiplier among REQUESTERS clients
module multiplier_arbiter #(
  parameter int BITS = 4,
  parameter int REQUESTERS = 2
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [REQUESTERS-1:0]    i_request,
  input  logic [REQUESTERS*BITS-1:0] i_multiplicand,
  input  logic [REQUESTERS*BITS-1:0] i_multiplier,
  output logic [REQUESTERS-1:0]    o_grant,
  output logic [REQUESTERS-1:0]    o_done,
  output logic [2*BITS-1:0]        o_product,
  output logic                     o_busy,
  output logic                     o_mul_start,
  output logic [BITS-1:0]          o_mul_multiplicand,
  output logic [BITS-1:0]          o_mul_multiplier,
  input  logic                     i_mul_finished,
  input  logic [2*BITS-1:0]        i_mul_product
);
  localparam int IW = $clog2(REQUESTERS);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t state;
  logic [IW-1:0] last, grant_idx, winner;
  always_comb begin
    winner = last;
    for (int i = REQUESTERS; i >= 1; i--)
      if (i_request[(int'(last) + i) % REQUESTERS]) winner = IW'((int'(last) + i) % REQUESTERS);
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state              <= IDLE;
      last               <= IW'(REQUESTERS - 1);
      grant_idx          <= '0;
      o_grant            <= '0;
      o_done             <= '0;
      o_busy             <= 1'b0;
      o_mul_start        <= 1'b0;
      o_mul_multiplicand <= '0;
      o_mul_multiplier   <= '0;
      o_product          <= '0;
    end else begin
      o_done      <= '0;
      o_mul_start <= 1'b0;
      case (state)
        IDLE: if (|i_request) begin
          grant_idx          <= winner;
          o_grant            <= REQUESTERS'(1) << winner;
          o_mul_multiplicand <= i_multiplicand[int'(winner)*BITS +: BITS];
          o_mul_multiplier   <= i_multiplier[int'(winner)*BITS +: BITS];
          o_mul_start        <= 1'b1;
          o_busy             <= 1'b1;
          state              <= START;
        end
        START: state <= WAIT;
        WAIT: if (i_mul_finished) begin
          o_product <= i_mul_product;
          o_done    <= o_grant;
          state     <= DONE;
        end
        default: begin
          last    <= grant_idx;
          o_grant <= '0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multiplier_arbiter.sv
// tb_multiplier_arbiter: directed self-checking bench with a 4-cycle multiplier model
module tb_multiplier_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [7:0] mcand = '0, mplier = '0;
  logic [1:0] grant, done;
  logic [7:0] product;
  logic       busy, mul_start, mul_fin, spur = 1'b0;
  logic [3:0] mul_mcand, mul_mplier;
  logic [7:0] mul_prod = '0;
  logic [3:0] sr = '0;
  int tests = 0, fails = 0;

  multiplier_arbiter #(.BITS(4), .REQUESTERS(2)) dut (
    .i_clock(clk), .i_reset(rst), .i_request(req),
    .i_multiplicand(mcand), .i_multiplier(mplier),
    .o_grant(grant), .o_done(done), .o_product(product), .o_busy(busy),
    .o_mul_start(mul_start), .o_mul_multiplicand(mul_mcand), .o_mul_multiplier(mul_mplier),
    .i_mul_finished(mul_fin), .i_mul_product(mul_prod)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    sr <= {sr[2:0], mul_start};
    if (mul_start) mul_prod <= {4'b0, mul_mcand} * {4'b0, mul_mplier};
  end
  assign mul_fin = sr[3] | spur;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done != 2'b00), 1);
  endtask

  task automatic op(input string tag, input logic [1:0] g, input logic [7:0] p, input bit chg, input bit withdraw);
    tick();
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_start"}, 32'(mul_start), 1);
    check({tag, "_busy"}, 32'(busy), 1);
    tick();
    if (chg) mcand[3:0] = 4'd5;
    if (chg) mplier[3:0] = 4'd5;
    if (withdraw) req = 2'b00;
    wait_done();
    check({tag, "_done"}, 32'(done), 32'(g));
    check({tag, "_product"}, 32'(product), 32'(p));
    tick();
    check({tag, "_idle_busy"}, 32'(busy), 0);
    check({tag, "_idle_grant"}, 32'(grant), 0);
  endtask

  initial begin
    int n, nfin;
    req = 2'b11;
    mcand = {4'd15, 4'd13};
    mplier = {4'd15, 4'd10};
    tick();
    tick();
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(mul_start), 0);
    check("rst_product", 32'(product), 0);
    check("rst_mcand", 32'(mul_mcand), 0);
    check("rst_mplier", 32'(mul_mplier), 0);
    rst = 1'b0;
    op("sim0", 2'b01, 8'd130, 0, 0);
    op("sim1", 2'b10, 8'd225, 0, 0);
    mcand = {4'd7, 4'd3};
    mplier = {4'd9, 4'd4};
    op("fair0", 2'b01, 8'd12, 1, 0);
    op("fair1", 2'b10, 8'd63, 0, 0);
    op("fair2", 2'b01, 8'd25, 0, 0);
    op("fair3", 2'b10, 8'd63, 0, 0);
    req = 2'b01;
    mcand = {4'd0, 4'd11};
    mplier = {4'd0, 4'd5};
    n = 1;
    nfin = 0;
    tick();
    n++;
    req = 2'b00;
    check("single_grant", 32'(grant), 1);
    check("single_start", 32'(mul_start), 1);
    check("single_mcand", 32'(mul_mcand), 11);
    check("single_mplier", 32'(mul_mplier), 5);
    tick();
    n++;
    check("single_start_pulse", 32'(mul_start), 0);
    while (done == 2'b00 && n < 30) begin
      tick();
      n++;
      if (mul_fin) nfin = n;
    end
    check("single_done", 32'(done), 1);
    check("single_product", 32'(product), 55);
    check("single_latency", 32'(n), 7);
    check("single_fin_to_done", 32'(n - nfin), 1);
    tick();
    req = 2'b01;
    mcand = {4'd0, 4'd9};
    mplier = {4'd0, 4'd9};
    tick();
    req = 2'b00;
    check("rw_start", 32'(mul_start), 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_grant", 32'(grant), 0);
    check("rw_busy", 32'(busy), 0);
    check("rw_product", 32'(product), 0);
    check("rw_mcand", 32'(mul_mcand), 0);
    check("rw_done", 32'(done), 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      spur = (i == 2);
      tick();
      n += int'(done != 2'b00);
    end
    spur = 1'b0;
    check("spur_done", 32'(n), 0);
    check("spur_product", 32'(product), 0);
    check("spur_busy", 32'(busy), 0);
    req = 2'b01;
    mcand = {4'd15, 4'd0};
    mplier = {4'd15, 4'd15};
    op("zero", 2'b01, 8'd0, 0, 0);
    req = 2'b10;
    op("withdraw", 2'b10, 8'd225, 0, 1);
    tick();
    check("final_busy", 32'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multiplier_arbiter.md
# multiplier_arbiter

Round-robin arbiter that shares one sequential `Multiplier` instance between `REQUESTERS` clients. It latches the winning client's operands, pulses the multiplier's start, waits for its finish, and returns the product to the granted client with a one-cycle done strobe. It sits between the client blocks and the shared `Multiplier`, which is driven from the same `i_clock` and `i_reset`.

## Interface
- `BITS`, default 4: operand width; the product is `2*BITS` wide.
- `REQUESTERS`, default 2: number of clients, minimum 2.

Ports:
- `i_clock`  in  1  system clock; all logic is on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_request`  in  REQUESTERS  per-client request level.
- `i_multiplicand`  in  REQUESTERS*BITS  packed operands; client k uses bits [k*BITS +: BITS].
- `i_multiplier`  in  REQUESTERS*BITS  packed operands, same packing as `i_multiplicand`.
- `o_grant`  out  REQUESTERS  one-hot owner of the multiplier; 0 when idle.
- `o_done`  out  REQUESTERS  one-cycle completion strobe to the owner.
- `o_product`  out  2*BITS  last captured product; holds until the next capture.
- `o_busy`  out  1  high in every state except IDLE.
- `o_mul_start`  out  1  start pulse to the multiplier.
- `o_mul_multiplicand`, `o_mul_multiplier`  out  BITS each  latched operands to the multiplier.
- `i_mul_finished`  in  1  multiplier completion pulse.
- `i_mul_product`  in  2*BITS  multiplier result; valid when `i_mul_finished` is high.

## Operation
- FSM states: IDLE, START, WAIT, DONE.
- IDLE:
  - If any `i_request` bit is high, select the winner by round-robin, searching from `last+1` upward with wrap-around.
  - Latch the winner's index and both operands, set `o_grant`, then go to START.
  - If no request is high, stay in IDLE.
- START: assert `o_mul_start` for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold `o_mul_start` low.
  - On `i_mul_finished`, capture `i_mul_product` into `o_product` and go to DONE.
  - Otherwise stay in WAIT indefinitely; there is no timeout.
- DONE:
  - Assert `o_done[grant]` for one cycle and set `last` to the grant index.
  - Go to IDLE and clear `o_grant` on the transition.
- `o_mul_multiplicand` and `o_mul_multiplier` are driven from the latched registers. Client operand changes after the latch have no effect on the operation in flight.
- Requests are level-sensitive. A client that holds `i_request` high past its `o_done` is treated as a new request in the next IDLE arbitration.
- Withdrawn request: if a client drops `i_request` after being granted, the operation still completes. `o_product` updates and `o_done` still pulses.
- `i_mul_finished` seen in IDLE, START or DONE is ignored. No capture takes place.
- The product is unsigned. `o_product` is exactly `i_mul_product`, with no truncation or extension.

## Timing
- Reset, applied in any state:
  - The next edge forces IDLE.
  - `o_grant`, `o_done`, `o_busy`, `o_mul_start`, `o_mul_multiplicand`, `o_mul_multiplier` and `o_product` all become 0.
  - `last` becomes `REQUESTERS-1`, so client 0 wins first.
  - An in-flight operation is dropped without `o_done`.
  - Reset has priority over every other event on the same edge.
- Cycle sequence, with edge k being the IDLE edge that sees the request:
  - After edge k: START; `o_mul_start`=1, `o_busy`=1 and `o_grant` is valid.
  - After edge k+1: WAIT.
  - The edge that samples `i_mul_finished`=1 leads to DONE, with `o_product` updated on that same edge.
  - The next edge leads to IDLE.
- Overhead is 3 cycles beyond the multiplier's own latency L, where L is measured from the `o_mul_start` cycle to the `i_mul_finished` cycle. The request-to-`o_done` gap is therefore L+3 cycles.
- The earliest next grant is the IDLE cycle immediately after DONE. There is no dead cycle beyond that.
- Under continuous requests from all clients, grants rotate 0,1,…,REQUESTERS-1 and then wrap.

## Test plan
Bench uses BITS=4, REQUESTERS=2, and a multiplier model with L=4.

- Reset: hold `i_reset` for 2 cycles with requests high -> every output is 0 and `o_busy`=0. After release, client 0 is granted first.
- Single request: client 0 presents 11×5 -> `o_mul_start` is high for one cycle with operands 11 and 5. `o_product`=55, and `o_done`=01 follows 1 cycle after `i_mul_finished`, 7 cycles after the request.
- Simultaneous requests after reset: client 0 presents 13×10 and client 1 presents 15×15 -> grants go 01 then 10. `o_product` reads 130 then 225, and each `o_done` matches its grant.
- Fairness: both clients hold requests through 4 operations -> the grant sequence is 01,10,01,10. Client 0 changing its operands during WAIT does not alter the product in flight.
- Reset during WAIT: assert `i_reset` 2 cycles after `o_mul_start` -> everything is 0 on the next edge, with no `o_done`. A spurious `i_mul_finished` afterwards is ignored and `o_product` stays 0.
- Edge values and withdrawal: 0×15 gives 0, and 15×15 gives 225. A client dropping its request during WAIT still receives `o_done`, and `o_product` updates.
